// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-feeder state encoding, data width,
// default buffer depth and the drop-counter saturation value.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int DEPTH_DEFAULT = 16;
  localparam logic [7:0] DROP_CNT_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } tx_state_e;
endpackage

// File: rtl/uart_tx_feeder_if.sv
// Producer/transmitter-side signal bundle of the UART transmit feeder.
// slave  : feeder view (takes writes and tx_busy, drives status and tx_start/tx_data)
// master : producer + transmitter view (the opposite directions)
interface uart_tx_feeder_if
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) ();
  localparam int AW = $clog2(DEPTH);

  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   full;
  logic                   empty;
  logic [AW:0]            count;
  logic [7:0]             drop_cnt;
  logic                   drop_clr;
  logic                   tx_start;
  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_busy;

  modport slave (
    input  wr_en, wr_data, drop_clr, tx_busy,
    output full, empty, count, drop_cnt, tx_start, tx_data
  );

  modport master (
    output wr_en, wr_data, drop_clr, tx_busy,
    input  full, empty, count, drop_cnt, tx_start, tx_data
  );
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO with a registered occupancy count; full/empty are
// registered from the next count so all three agree in the same cycle.
// Ports: clk, reset (sync, active high), wr_en/wr_data (write side),
//        rd_en/rd_data (read side, rd_data shows the head combinationally),
//        full, empty, count (0..DEPTH).
module fifo_sync #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count, w_count_nxt;
  logic          r_full, r_empty;
  logic          w_wr_acc, w_rd_acc;

  // A write into a full FIFO is refused even if a read frees a slot
  // in the same cycle.
  assign w_wr_acc = wr_en & ~r_full;
  assign w_rd_acc = rd_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Pointers are exactly AW bits wide, so they wrap mod DEPTH for free.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rptr];
  assign full    = r_full;
  assign empty   = r_empty;
  assign count   = r_count;
endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them to the UART transmitter one at a
// time, issuing a single tx_start pulse whenever the transmitter is idle.
// Overflowing writes are counted in a saturating drop counter.
// Ports: clk, reset (sync, active high), bus (slave modport): wr_en/wr_data,
//        full/empty/count, drop_cnt/drop_clr, tx_start/tx_data/tx_busy.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  uart_tx_feeder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  tx_state_e              r_state, w_state_nxt;
  logic                   w_pop;
  logic [UART_DATA_W-1:0] w_head;
  logic                   w_full, w_empty;
  logic [AW:0]            w_count;
  logic                   r_tx_start;
  logic [UART_DATA_W-1:0] r_tx_data;
  logic [7:0]             r_drop_cnt;
  logic                   w_drop;

  fifo_sync #(.DEPTH(DEPTH), .W(UART_DATA_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_data (bus.wr_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  // IDLE also checks tx_busy so that after a reset mid-character the
  // next start waits for the (unreset) transmitter to finish.
  // HOLD ignores tx_busy: it only rises the cycle after tx_start.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: if (!w_empty && !bus.tx_busy) begin
        w_pop       = 1'b1;
        w_state_nxt = START;
      end
      START:   w_state_nxt = HOLD;
      HOLD:    w_state_nxt = DRAIN;
      DRAIN:   if (!bus.tx_busy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // tx_start is registered from the next state, so it is high exactly
  // during the START cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tx_start <= (w_state_nxt == START);
      if (w_pop) r_tx_data <= w_head;
    end
  end

  assign w_drop = bus.wr_en & w_full;

  // Clear wins over a same-cycle drop.
  always_ff @(posedge clk) begin
    if (reset || bus.drop_clr)
      r_drop_cnt <= '0;
    else if (w_drop && r_drop_cnt != DROP_CNT_MAX)
      r_drop_cnt <= r_drop_cnt + 8'd1;
  end

  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.count    = w_count;
  assign bus.drop_cnt = r_drop_cnt;
  assign bus.tx_start = r_tx_start;
  assign bus.tx_data  = r_tx_data;
endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a per-cycle vector table for single-byte and
// write-while-pop timing, then sequences using a simple transmitter model.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_feeder #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_pass = 0;

  // Transmitter model: busy for blen cycles starting the cycle after a start.
  logic busy_tbl = 1'b0;
  logic force_busy = 1'b0;
  bit   model_en = 1'b0;
  int   blen = 3;
  int   bcnt = 0;
  int   bad_starts = 0;
  logic [7:0] starts[$];

  assign bus.tx_busy = busy_tbl | force_busy | (bcnt != 0);

  always @(posedge clk) begin
    if (bcnt != 0) bcnt <= bcnt - 1;
    if (model_en && bus.tx_start) begin
      bcnt <= blen;
      starts.push_back(bus.tx_data);
      if (bus.tx_busy) bad_starts <= bad_starts + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string nm);
    for (int k = 0; k < budget && starts.size() < n; k++) cyc();
    chk(nm, starts.size(), n);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic       st;
    logic [7:0] td;
    int         cnt;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.drop_clr = 1'b0;

    // Single byte, then a write coinciding with a pop at occupancy 1.
    tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 0};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0};
    tbl[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 0};
    tbl[5]  = '{1'b1, 8'h11, 1'b1, 1'b0, 8'hA5, 1};
    tbl[6]  = '{1'b1, 8'h22, 1'b0, 1'b1, 8'h11, 1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h22, 0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 0};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h22, 0};

    @(negedge clk);
    do_reset();
    chk("rst tx_start", bus.tx_start, 0);
    chk("rst tx_data", bus.tx_data, 8'h00);
    chk("rst full", bus.full, 0);
    chk("rst empty", bus.empty, 1);
    chk("rst count", bus.count, 0);
    chk("rst drop_cnt", bus.drop_cnt, 0);

    foreach (tbl[i]) begin
      bus.wr_en = tbl[i].wr;
      bus.wr_data = tbl[i].d;
      busy_tbl = tbl[i].busy;
      cyc();
      chk($sformatf("vec%0d tx_start", i), bus.tx_start, tbl[i].st);
      chk($sformatf("vec%0d tx_data", i), bus.tx_data, tbl[i].td);
      chk($sformatf("vec%0d count", i), bus.count, tbl[i].cnt);
      chk($sformatf("vec%0d empty", i), bus.empty, tbl[i].cnt == 0);
      chk($sformatf("vec%0d drop_cnt", i), bus.drop_cnt, 0);
    end
    bus.wr_en = 1'b0;
    busy_tbl = 1'b0;

    // Four back-to-back bytes with the transmitter model active.
    model_en = 1'b1;
    blen = 3;
    do_reset();
    starts.delete();
    bad_starts = 0;
    for (int i = 1; i <= 4; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i);
      cyc();
    end
    bus.wr_en = 1'b0;
    for (int k = 0; k < 40; k++) cyc();
    chk("burst4 starts", starts.size(), 4);
    for (int i = 0; i < 4 && i < starts.size(); i++)
      chk($sformatf("burst4 byte%0d", i), starts[i], i + 1);
    chk("burst4 start while busy", bad_starts, 0);

    // Overflow while the transmitter is held busy.
    do_reset();
    starts.delete();
    bad_starts = 0;
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h40 + 8'(i);
      cyc();
    end
    bus.wr_en = 1'b0;
    chk("ovf full", bus.full, 1);
    chk("ovf count", bus.count, DEPTH);
    chk("ovf drop_cnt", bus.drop_cnt, 3);
    chk("ovf no start", starts.size(), 0);
    force_busy = 1'b0;
    wait_starts(DEPTH, 200, "ovf drain starts");
    for (int i = 0; i < DEPTH && i < starts.size(); i++)
      chk($sformatf("ovf byte%0d", i), starts[i], 8'h40 + i);
    for (int k = 0; k < 10; k++) cyc();
    chk("ovf drained empty", bus.empty, 1);
    chk("ovf total starts", starts.size(), DEPTH);
    chk("ovf start while busy", bad_starts, 0);

    // Drop counter saturation and clear-vs-drop priority.
    do_reset();
    force_busy = 1'b1;
    for (int i = 0; i < DEPTH + 260; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i);
      cyc();
    end
    chk("sat drop_cnt", bus.drop_cnt, 255);
    bus.drop_clr = 1'b1;
    cyc();
    bus.drop_clr = 1'b0;
    chk("clr with drop", bus.drop_cnt, 0);
    cyc();
    bus.wr_en = 1'b0;
    chk("drop after clr", bus.drop_cnt, 1);
    force_busy = 1'b0;

    // Reset during DRAIN while the transmitter is still busy.
    blen = 10;
    do_reset();
    for (int k = 0; k < 12; k++) cyc();
    starts.delete();
    bad_starts = 0;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h77;
    cyc();
    bus.wr_data = 8'h88;
    cyc();
    bus.wr_en = 1'b0;
    wait_starts(1, 20, "mid first start");
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid rst empty", bus.empty, 1);
    chk("mid rst count", bus.count, 0);
    chk("mid rst busy held", bus.tx_busy, 1);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h99;
    cyc();
    bus.wr_en = 1'b0;
    wait_starts(2, 40, "mid second start");
    if (starts.size() >= 2) begin
      chk("mid byte0", starts[0], 8'h77);
      chk("mid byte1", starts[1], 8'h99);
    end
    chk("mid start while busy", bad_starts, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Byte buffer and handshake sequencer that sits directly upstream of the UART transmitter on the diagnostic/monitoring link. Producers write bytes at up to one per clock into an internal FIFO. The feeder issues one `tx_start` pulse per byte whenever the transmitter is idle, so bursts of housekeeping data are never lost to a busy serial line. Overflow is counted, not silently ignored.

## Interface
- `DEPTH`, 16: FIFO depth in bytes; power of two, 2..256.
- `AW`, log2(`DEPTH`): pointer width; derived, not overridden.

- `clk`  in  1  system clock (10 MHz nominal).
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  write strobe; one byte per asserted cycle.
- `wr_data`  in  8  byte to enqueue.
- `full`  out  1  FIFO holds `DEPTH` bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  AW+1  current occupancy, 0..`DEPTH`.
- `drop_cnt`  out  8  bytes dropped on overflow; saturates at 255.
- `drop_clr`  in  1  clears `drop_cnt` on the next edge.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_data`  out  8  byte presented with `tx_start`; held until the next pop.
- `tx_busy`  in  1  transmitter busy. Rises the cycle after an accepted `tx_start` and stays high through both stop bits.

## Operation
- All outputs are registered. Reset values:
  - `tx_start`=0, `tx_data`=8'h00
  - `full`=0, `empty`=1, `count`=0, `drop_cnt`=0
  - pointers=0, state=IDLE
- Write: if `wr_en` and not `full`, store at `wptr`, then `wptr`+1 (wraps mod `DEPTH`).
- Write while `full` is dropped, even if a pop occurs in the same cycle. `drop_cnt`+1, saturating at 8'hFF.
- `drop_clr` has priority over a same-cycle increment: the result is 0.
- `count` logic:
  - simultaneous accepted write and pop: `count` unchanged
  - write only: +1
  - pop only: −1
- `full`/`empty` are derived from the next `count`, so they are valid in the same cycle as `count`.
- State machine:
  - IDLE: if not `empty` and not `tx_busy`, pop the head into `tx_data` and go to START.
  - START: `tx_start`=1 for exactly this cycle; go to HOLD.
  - HOLD: one guard cycle; `tx_busy` is ignored, because the transmitter's busy lags start by one cycle. Go to DRAIN.
  - DRAIN: when `tx_busy`=0, go to IDLE.
- `tx_data` changes only on a pop. It is stable from the pop through DRAIN.
- Reset mid-transmission:
  - FIFO is emptied and the state returns to IDLE.
  - The transmitter (which has no reset) finishes its character.
  - IDLE waits on `tx_busy` before the next start, so no character is ever truncated.

## Timing
- Write to empty FIFO at cycle 0 (transmitter idle):
  - `count`=1, `empty`=0 at cycle 1
  - pop at the cycle-1 edge; `tx_start`=1 during cycle 2
- Minimum inter-start spacing: 3 cycles plus the transmitter busy time, i.e. IDLE→START→HOLD→DRAIN plus one cycle back in IDLE.
- At 115200 baud and 10 MHz, roughly 955 cycles per byte. The feeder overhead is negligible.
- `count` reflects a write or pop one cycle after the triggering edge.

## Structure
- Shared package `uart_pkg`:
  - state enum (IDLE, START, HOLD, DRAIN)
  - `UART_DATA_W`=8
  - default `DEPTH`
  - `DROP_CNT_MAX`=8'hFF
- Sub-module `fifo_sync`:
  - single-clock, registered-count FIFO with `wr_en`/`rd_en`/`full`/`empty`/`count`
  - reusable for the receive side
- `uart_tx_feeder` contains the FSM, the drop counter, and the `fifo_sync` instance.

## Test plan
- Reset, then write 8'hA5 at cycle 0 with `tx_busy`=0:
  - `tx_start` pulses only at cycle 2 with `tx_data`=8'hA5
  - `count` returns to 0
- Write 4 bytes back-to-back; model `tx_busy` high 1 cycle after each start, for 20 cycles:
  - exactly 4 starts, in order 01,02,03,04
  - none while `tx_busy`=1
- Hold `tx_busy`=1 and write `DEPTH`+3 bytes:
  - `full`=1, `count`=16, `drop_cnt`=3
  - the first 16 bytes transmit in order afterward
- Force `drop_cnt` to 255 and overflow again:
  - `drop_cnt` stays 255
  - `drop_clr` plus a simultaneous drop gives 0
- Assert `reset` during DRAIN with `tx_busy`=1:
  - `empty`=1 next cycle, no `tx_start` until `tx_busy` falls
  - new writes then transmit normally
- With the FIFO at 1 byte, write and pop in the same cycle:
  - `count` stays 1
  - no drop counted
